// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding, owner
// encoding and the default access latency.
package mem_arb_pkg;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 5;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_ACCESS = 2'd1;
  localparam arb_state_t ST_DONE   = 2'd2;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and MEM stages onto one single-port memory with a
// fixed access latency; MEM always wins a simultaneous request.
module mem_port_arbiter #(
  parameter int unsigned N           = 32,
  parameter int unsigned WAIT_CYCLES = mem_arb_pkg::WAIT_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ifReqIn,
  input  logic [N-1:0] ifAddrIn,
  input  logic         memRdReqIn,
  input  logic         memWrReqIn,
  input  logic [N-1:0] memAddrIn,
  input  logic [N-1:0] memWrDataIn,
  output logic         ifReadyOut,
  output logic         memReadyOut,
  output logic [N-1:0] ifDataOut,
  output logic [N-1:0] memRdDataOut,
  output logic         ifStallOut,
  output logic         memStallOut,
  output logic         ramEnOut,
  output logic         ramWeOut,
  output logic [N-1:0] ramAddrOut,
  output logic [N-1:0] ramWrDataOut,
  input  logic [N-1:0] ramRdDataIn
);
  import mem_arb_pkg::*;

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  arb_state_t   state_q, state_d;
  logic         owner_q, owner_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] cap_q, cap_d;
  logic         cnt_load, cnt_dec, cnt_zero;
  logic         mem_req, in_access, in_done;

  assign mem_req = memRdReqIn | memWrReqIn;

  wait_counter #(.W(CW)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cap_d    = cap_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          owner_d  = OWNER_MEM;
          addr_d   = memAddrIn;
          wdata_d  = memWrDataIn;
          we_d     = memWrReqIn;
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end else if (ifReqIn) begin
          owner_d  = OWNER_IF;
          addr_d   = ifAddrIn;
          wdata_d  = '0;
          we_d     = 1'b0;
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          if (!we_q) begin
            cap_d = ramRdDataIn;
          end
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  assign ramEnOut     = in_access;
  assign ramWeOut     = in_access & we_q;
  assign ramAddrOut   = in_access ? addr_q  : '0;
  assign ramWrDataOut = in_access ? wdata_q : '0;

  assign ifReadyOut   = in_done & (owner_q == OWNER_IF);
  assign memReadyOut  = in_done & (owner_q == OWNER_MEM);
  assign ifDataOut    = ifReadyOut  ? cap_q : '0;
  assign memRdDataOut = memReadyOut ? cap_q : '0;

  // Stalls are combinational from the requests, so gate them to keep every
  // output low while reset is held.
  assign ifStallOut  = ~rst & ifReqIn & ~ifReadyOut;
  assign memStallOut = ~rst & mem_req & ~memReadyOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a ready-pulse scoreboard and a
// small behavioural RAM behind the shared port.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        ifReqIn, memRdReqIn, memWrReqIn;
  logic [31:0] ifAddrIn, memAddrIn, memWrDataIn;
  logic        ifReadyOut, memReadyOut, ifStallOut, memStallOut, ramEnOut, ramWeOut;
  logic [31:0] ifDataOut, memRdDataOut, ramAddrOut, ramWrDataOut, ramRdDataIn;

  logic        ifReqIn1;
  logic [31:0] ifAddrIn1;
  logic        ifReadyOut1, memReadyOut1, ifStallOut1, memStallOut1, ramEnOut1, ramWeOut1;
  logic [31:0] ifDataOut1, memRdDataOut1, ramAddrOut1, ramWrDataOut1, ramRdDataIn1;

  logic [31:0] mem [0:1023];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned c0, c1;

  typedef struct {
    bit          is_mem;
    int unsigned cyc;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mem_port_arbiter #(.N(32), .WAIT_CYCLES(5)) dut (
    .clk(clk), .rst(rst),
    .ifReqIn(ifReqIn), .ifAddrIn(ifAddrIn),
    .memRdReqIn(memRdReqIn), .memWrReqIn(memWrReqIn),
    .memAddrIn(memAddrIn), .memWrDataIn(memWrDataIn),
    .ifReadyOut(ifReadyOut), .memReadyOut(memReadyOut),
    .ifDataOut(ifDataOut), .memRdDataOut(memRdDataOut),
    .ifStallOut(ifStallOut), .memStallOut(memStallOut),
    .ramEnOut(ramEnOut), .ramWeOut(ramWeOut),
    .ramAddrOut(ramAddrOut), .ramWrDataOut(ramWrDataOut),
    .ramRdDataIn(ramRdDataIn)
  );

  mem_port_arbiter #(.N(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .ifReqIn(ifReqIn1), .ifAddrIn(ifAddrIn1),
    .memRdReqIn(1'b0), .memWrReqIn(1'b0),
    .memAddrIn(32'h0), .memWrDataIn(32'h0),
    .ifReadyOut(ifReadyOut1), .memReadyOut(memReadyOut1),
    .ifDataOut(ifDataOut1), .memRdDataOut(memRdDataOut1),
    .ifStallOut(ifStallOut1), .memStallOut(memStallOut1),
    .ramEnOut(ramEnOut1), .ramWeOut(ramWeOut1),
    .ramAddrOut(ramAddrOut1), .ramWrDataOut(ramWrDataOut1),
    .ramRdDataIn(ramRdDataIn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ramRdDataIn  = mem[ramAddrOut[11:2]];
  always @(posedge clk) if (ramEnOut && ramWeOut) mem[ramAddrOut[11:2]] <= ramWrDataOut;
  assign ramRdDataIn1 = ramAddrOut1 ^ 32'hA5A5_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (ifReadyOut || memReadyOut)) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {62'b0, ifReadyOut, memReadyOut}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ready_mem", {63'b0, memReadyOut}, {63'b0, mon_e.is_mem});
        check("ready_if", {63'b0, ifReadyOut}, {63'b0, !mon_e.is_mem});
        check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
        if (mon_e.chk_data)
          check("ready_data", {32'b0, mon_e.is_mem ? memRdDataOut : ifDataOut}, {32'b0, mon_e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ifReqIn = 1'b1; ifAddrIn = 32'h10; memRdReqIn = 1'b1; memWrReqIn = 1'b0;
    memAddrIn = 32'h0; memWrDataIn = 32'h0; ifReqIn1 = 1'b0; ifAddrIn1 = 32'h20;
    for (int unsigned i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
    mem[4]   = 32'hE3A0_1005;
    mem[256] = 32'h1234_5678;

    // Reset holds every output low even with requests pending
    @(negedge clk);
    check("rst_ctrl", {58'b0, ifReadyOut, memReadyOut, ifStallOut, memStallOut, ramEnOut, ramWeOut}, 64'd0);
    check("rst_data", {32'b0, ifDataOut | memRdDataOut | ramAddrOut | ramWrDataOut}, 64'd0);
    ifReqIn = 1'b0; memRdReqIn = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // IF fetch alone
    @(posedge clk); #1;
    ifReqIn = 1'b1; ifAddrIn = 32'h10; c0 = cyc;
    sb.push_back('{1'b0, c0 + 6, 32'hE3A0_1005, 1'b1});
    for (int unsigned k = 0; k <= 6; k++) begin
      @(negedge clk);
      check("t1_ram_en", {63'b0, ramEnOut}, {63'b0, (k >= 1 && k <= 5)});
      check("t1_if_stall", {63'b0, ifStallOut}, {63'b0, (k <= 5)});
      if (k == 1) check("t1_addr", {32'b0, ramAddrOut}, 64'h10);
    end
    ifReqIn = 1'b0;

    // IF and MEM load together: MEM first, IF afterwards
    @(posedge clk); #1;
    ifReqIn = 1'b1; memRdReqIn = 1'b1; memAddrIn = 32'h400; c0 = cyc;
    sb.push_back('{1'b1, c0 + 6, 32'h1234_5678, 1'b1});
    sb.push_back('{1'b0, c0 + 13, 32'hE3A0_1005, 1'b1});
    for (int unsigned k = 0; k <= 13; k++) begin
      @(negedge clk);
      check("t2_if_stall", {63'b0, ifStallOut}, {63'b0, (k <= 12)});
      check("t2_mem_stall", {63'b0, memStallOut}, {63'b0, (k <= 5)});
      if (k == 1) check("t2_addr_mem", {32'b0, ramAddrOut}, 64'h400);
      if (k == 8) check("t2_addr_if", {32'b0, ramAddrOut}, 64'h10);
      if (k == 6) memRdReqIn = 1'b0;
    end
    ifReqIn = 1'b0;

    // Store with both MEM requests high; inputs change mid-access
    @(posedge clk); #1;
    memRdReqIn = 1'b1; memWrReqIn = 1'b1; memAddrIn = 32'h404; memWrDataIn = 32'hDEAD_BEEF; c0 = cyc;
    sb.push_back('{1'b1, c0 + 6, 32'h0, 1'b0});
    for (int unsigned k = 0; k <= 6; k++) begin
      @(negedge clk);
      check("t3_ram_we", {63'b0, ramWeOut}, {63'b0, (k >= 1 && k <= 5)});
      if (k == 3) begin
        check("t3_addr_held", {32'b0, ramAddrOut}, 64'h404);
        check("t3_wdata_held", {32'b0, ramWrDataOut}, 64'hDEAD_BEEF);
      end
      if (k == 2) begin memAddrIn = 32'h800; memWrDataIn = 32'h0BAD_0BAD; end
    end
    memRdReqIn = 1'b0; memWrReqIn = 1'b0;

    // Load back the stored word
    @(posedge clk); #1;
    memRdReqIn = 1'b1; memAddrIn = 32'h404; c0 = cyc;
    sb.push_back('{1'b1, c0 + 6, 32'hDEAD_BEEF, 1'b1});
    for (int unsigned k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) check("t3b_ram_we", {63'b0, ramWeOut}, 64'd0);
    end
    memRdReqIn = 1'b0;

    // Fetch withdrawn at t+2 still completes
    @(posedge clk); #1;
    ifReqIn = 1'b1; ifAddrIn = 32'h10; c0 = cyc;
    sb.push_back('{1'b0, c0 + 6, 32'hE3A0_1005, 1'b1});
    for (int unsigned k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("t4_ram_en", {63'b0, ramEnOut}, {63'b0, (k >= 1 && k <= 5)});
      check("t4_if_stall", {63'b0, ifStallOut}, {63'b0, (k <= 1)});
      if (k == 1) ifReqIn = 1'b0;
    end

    // Reset mid-access abandons it; a fresh request afterwards completes
    @(posedge clk); #1;
    ifReqIn = 1'b1; c0 = cyc;
    for (int unsigned k = 0; k <= 2; k++) begin
      @(negedge clk);
      check("t5_ram_en", {63'b0, ramEnOut}, {63'b0, (k >= 1)});
    end
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ctrl", {58'b0, ifReadyOut, memReadyOut, ifStallOut, memStallOut, ramEnOut, ramWeOut}, 64'd0);
    check("t5_rst_data", {32'b0, ifDataOut | memRdDataOut | ramAddrOut | ramWrDataOut}, 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    c1 = cyc;
    sb.push_back('{1'b0, c1 + 6, 32'hE3A0_1005, 1'b1});
    for (int unsigned k = 0; k <= 6; k++) begin
      @(negedge clk);
      check("t5_ram_en_after", {63'b0, ramEnOut}, {63'b0, (k >= 1 && k <= 5)});
    end
    ifReqIn = 1'b0;

    // WAIT_CYCLES=1 instance, fetch held continuously
    @(posedge clk); #1;
    ifReqIn1 = 1'b1; c0 = cyc;
    for (int unsigned k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("t6_ready", {63'b0, ifReadyOut1}, {63'b0, (k == 2 || k == 5 || k == 8)});
      check("t6_ram_en", {63'b0, ramEnOut1}, {63'b0, (k == 1 || k == 4 || k == 7)});
      check("t6_if_stall", {63'b0, ifStallOut1}, {63'b0, !(k == 2 || k == 5 || k == 8)});
      check("t6_mem_quiet", {61'b0, memReadyOut1, memStallOut1, ramWeOut1}, 64'd0);
      check("t6_mem_data", {32'b0, memRdDataOut1 | ramWrDataOut1}, 64'd0);
      if (k == 2 || k == 5 || k == 8) check("t6_data", {32'b0, ifDataOut1}, 64'hA5A5_0020);
    end
    ifReqIn1 = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning the address and data width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 5, meaning the fixed memory access latency in cycles (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ifReqIn, input, 1 bit: fetch-stage read request, held until ifReadyOut.
REQ-006 SHALL have port ifAddrIn, input, N bits: fetch address (PC).
REQ-007 SHALL have ports memRdReqIn and memWrReqIn, input, 1 bit each: MEM-stage load and store requests, held until memReadyOut; both high is treated as a write.
REQ-008 SHALL have ports memAddrIn and memWrDataIn, input, N bits each: MEM-stage address and store data.
REQ-009 SHALL have ports ifReadyOut and memReadyOut, output, 1 bit each: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have ports ifDataOut and memRdDataOut, output, N bits each: returned read data, valid while the matching ready is high.
REQ-011 SHALL have ports ifStallOut and memStallOut, output, 1 bit each: request pending and not yet ready (freeze sources for the pipeline).
REQ-012 SHALL have ports ramEnOut and ramWeOut, output, 1 bit each; ramAddrOut and ramWrDataOut, output, N bits each; ramRdDataIn, input, N bits: shared single-port memory.

Function
REQ-013 SHALL implement the states IDLE, ACCESS and DONE.
REQ-014 In IDLE with a MEM request SHALL grant MEM; else with ifReqIn SHALL grant IF; else SHALL stay in IDLE.
REQ-015 On grant SHALL latch owner, address, write data and write flag, load the counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-016 In ACCESS SHALL drive ramEnOut=1, ramWeOut=latched write flag, and ramAddrOut/ramWrDataOut from the latched values; inputs changing mid-access SHALL have no effect.
REQ-017 In ACCESS SHALL decrement the counter each cycle; at counter==0 SHALL capture ramRdDataIn (reads only) and enter DONE.
REQ-018 In DONE SHALL assert the owner's ready for exactly one cycle, with data from the capture register, then return to IDLE.
REQ-019 Latency SHALL be: request sampled in IDLE at cycle t, ready high at cycle t+WAIT_CYCLES+1.
REQ-020 Simultaneous IF and MEM requests SHALL grant MEM first; IF SHALL be granted at the next IDLE if still requesting.
REQ-021 A request withdrawn during ACCESS (e.g. fetch flush on branch) SHALL NOT abort the access; the ready pulse SHALL still issue.
REQ-022 ifStallOut SHALL be ifReqIn & ~ifReadyOut; memStallOut SHALL be (memRdReqIn|memWrReqIn) & ~memReadyOut.
REQ-023 Outside ACCESS, ramEnOut and ramWeOut SHALL be 0.
REQ-024 The counter SHALL be ceil(log2(WAIT_CYCLES+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-025 On rst, SHALL enter IDLE asynchronously and clear the counter, the latched owner, address, data and capture registers.
REQ-026 While rst is high, all outputs SHALL be 0; reset during ACCESS SHALL abandon the access with no ready pulse.

Structure
REQ-027 The state encoding and the WAIT_CYCLES default SHALL live in shared package mem_arb_pkg.
REQ-028 The down-counter SHALL be sub-module wait_counter (load, decrement, zero flag); the FSM and datapath SHALL be in mem_port_arbiter.

Verification
REQ-029 IF only, ifAddrIn=0x10, memory word 0x10=0xE3A01005, WAIT=5 -> ramEnOut high cycles t+1..t+5, ifReadyOut at t+6 with ifDataOut=0xE3A01005.
REQ-030 IF and MEM load together, memAddrIn=0x400 -> MEM ready at t+6, IF ready at t+13, ifStallOut high through t+12.
REQ-031 Store memAddrIn=0x404, data 0xDEADBEEF -> ramWeOut high 5 cycles, memReadyOut at t+6, later load of 0x404 returns 0xDEADBEEF.
REQ-032 ifReqIn dropped at t+2 -> access completes, ifReadyOut still pulses at t+6, then IDLE.
REQ-033 rst asserted at t+3 mid-access -> immediate IDLE, all outputs 0, no ready pulse; a fresh request after release completes normally.
REQ-034 WAIT_CYCLES=1 -> ready at t+2 for back-to-back IF requests, with one IDLE cycle between grants.
